// File: rtl/layer0_pkg.sv
// Shared layer-0 constants: stream geometry, line-buffer widths and
// the beats-per-row figures the transmitter also builds against.
package layer0_pkg;

    localparam int IMG_W    = 416;
    localparam int NUM_ROWS = 4;
    localparam int DATA_W   = 64;

    localparam int COL_W     = 9;
    localparam int BANK_W    = 2;
    localparam int RAM_AW    = 11;
    localparam int RAM_DEPTH = NUM_ROWS * IMG_W;

    localparam int L0_BYTES_PER_BEAT = DATA_W / 8;
    localparam int L0_BEATS_PER_ROW  = IMG_W;
    localparam int L0_BYTES_PER_ROW  = L0_BEATS_PER_ROW * L0_BYTES_PER_BEAT;

    // Increment with wrap at m (m need not be a power of two).
    function automatic int unsigned wrap_inc(
        input int unsigned v,
        input int unsigned m
    );
        return (v + 1 >= m) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/layer0_line_buffer_if.sv
// Layer-0 feature stream handshake: data/valid/last forward, ready back.
// master = stream source, slave = line buffer.
interface layer0_line_buffer_if #(
    parameter int DATA_W = layer0_pkg::DATA_W
) ();

    logic [DATA_W-1:0] feature_data;
    logic              feature_valid;
    logic              feature_last;
    logic              ready;

    modport master (
        output feature_data,
        output feature_valid,
        output feature_last,
        input  ready
    );

    modport slave (
        input  feature_data,
        input  feature_valid,
        input  feature_last,
        output ready
    );

endinterface

// File: rtl/feature_row_ram.sv
// Simple dual-port row RAM: one write port, one registered read port.
// Ports: clk_i/rst_i, we_i/waddr_i/wdata_i, re_i/raddr_i -> rdata_o.
module feature_row_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1664,
    parameter int AW     = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array is not reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking read of the array yields old data on a same-address write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/layer0_line_buffer.sv
// Layer-0 line buffer: writes 416-beat rows into circular RAM banks and
// offers completed rows through a registered random-access read port.
// Ports: sclk/s_rst, feat (stream slave), rd_en/rd_bank/rd_addr -> rd_data,
// row_release, rows_full, head_bank, row_done/done_bank, err_misalign,
// err_underflow.
module layer0_line_buffer #(
    parameter int IMG_W    = layer0_pkg::IMG_W,
    parameter int NUM_ROWS = layer0_pkg::NUM_ROWS,
    parameter int DATA_W   = layer0_pkg::DATA_W
) (
    input  logic                          sclk,
    input  logic                          s_rst,
    layer0_line_buffer_if.slave           feat,
    input  logic                          rd_en,
    input  logic [$clog2(NUM_ROWS)-1:0]   rd_bank,
    input  logic [$clog2(IMG_W)-1:0]      rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          row_release,
    output logic [$clog2(NUM_ROWS+1)-1:0] rows_full,
    output logic [$clog2(NUM_ROWS)-1:0]   head_bank,
    output logic                          row_done,
    output logic [$clog2(NUM_ROWS)-1:0]   done_bank,
    output logic                          err_misalign,
    output logic                          err_underflow
);

    import layer0_pkg::*;

    localparam int COL_BITS  = $clog2(IMG_W);
    localparam int BANK_BITS = $clog2(NUM_ROWS);
    localparam int CNT_BITS  = $clog2(NUM_ROWS + 1);
    localparam int DEPTH     = NUM_ROWS * IMG_W;
    localparam int ADDR_BITS = $clog2(DEPTH);

    logic [COL_BITS-1:0]  col_q, col_d;
    logic [BANK_BITS-1:0] wr_bank_q, wr_bank_d;
    logic [BANK_BITS-1:0] head_bank_q, head_bank_d;
    logic [BANK_BITS-1:0] done_bank_q, done_bank_d;
    logic [CNT_BITS-1:0]  rows_full_q, rows_full_d;
    logic                 writing_q, writing_d;
    logic                 row_done_q, row_done_d;
    logic                 err_mis_q, err_mis_d;
    logic                 err_und_q, err_und_d;

    logic accept;
    logic col_end;
    logic beat_end;
    logic beat_abort;
    logic beat_mid;
    logic rel_ok;
    logic rel_bad;

    logic [BANK_BITS-1:0] wr_bank_nxt;
    logic [BANK_BITS-1:0] head_nxt;
    logic [ADDR_BITS-1:0] waddr;
    logic [ADDR_BITS-1:0] raddr;

    // An open row already owns its bank, so it may always finish;
    // a new row needs a bank that holds no unreleased row.
    assign feat.ready = writing_q | (rows_full_q < CNT_BITS'(NUM_ROWS));

    assign accept  = feat.feature_valid & feat.ready;
    assign col_end = (col_q == COL_BITS'(IMG_W - 1));

    // Mutually exclusive beat outcomes.
    assign beat_end   = accept & col_end;
    assign beat_abort = accept & ~col_end & feat.feature_last;
    assign beat_mid   = accept & ~col_end & ~feat.feature_last;

    assign rel_ok  = row_release & (rows_full_q != '0);
    assign rel_bad = row_release & (rows_full_q == '0);

    assign wr_bank_nxt = BANK_BITS'(wrap_inc(32'(wr_bank_q), NUM_ROWS));
    assign head_nxt    = BANK_BITS'(wrap_inc(32'(head_bank_q), NUM_ROWS));

    assign waddr = ADDR_BITS'(32'(wr_bank_q) * IMG_W + 32'(col_q));
    assign raddr = ADDR_BITS'(32'(rd_bank) * IMG_W + 32'(rd_addr));

    always_comb begin
        col_d       = col_q;
        writing_d   = writing_q;
        wr_bank_d   = wr_bank_q;
        done_bank_d = done_bank_q;
        row_done_d  = 1'b0;
        err_mis_d   = err_mis_q | beat_abort;
        err_und_d   = err_und_q | rel_bad;

        unique case (1'b1)
            beat_end: begin
                col_d       = '0;
                writing_d   = 1'b0;
                wr_bank_d   = wr_bank_nxt;
                row_done_d  = 1'b1;
                done_bank_d = wr_bank_q;
            end
            beat_abort: begin
                // Partial row is dropped; its bank is reused.
                col_d     = '0;
                writing_d = 1'b0;
            end
            beat_mid: begin
                col_d     = col_q + COL_BITS'(1);
                writing_d = 1'b1;
            end
            default: begin
            end
        endcase

        // rel_ok implies >=1 and beat_end alone implies <NUM_ROWS,
        // so this never wraps.
        rows_full_d = rows_full_q
                    + CNT_BITS'(beat_end)
                    - CNT_BITS'(rel_ok);
        head_bank_d = rel_ok ? head_nxt : head_bank_q;
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            col_q       <= '0;
            wr_bank_q   <= '0;
            head_bank_q <= '0;
            done_bank_q <= '0;
            rows_full_q <= '0;
            writing_q   <= 1'b0;
            row_done_q  <= 1'b0;
            err_mis_q   <= 1'b0;
            err_und_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            wr_bank_q   <= wr_bank_d;
            head_bank_q <= head_bank_d;
            done_bank_q <= done_bank_d;
            rows_full_q <= rows_full_d;
            writing_q   <= writing_d;
            row_done_q  <= row_done_d;
            err_mis_q   <= err_mis_d;
            err_und_q   <= err_und_d;
        end
    end

    feature_row_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (ADDR_BITS)
    ) u_ram (
        .clk_i   (sclk),
        .rst_i   (s_rst),
        .we_i    (accept),
        .waddr_i (waddr),
        .wdata_i (feat.feature_data),
        .re_i    (rd_en),
        .raddr_i (raddr),
        .rdata_o (rd_data)
    );

    assign rows_full     = rows_full_q;
    assign head_bank     = head_bank_q;
    assign row_done      = row_done_q;
    assign done_bank     = done_bank_q;
    assign err_misalign  = err_mis_q;
    assign err_underflow = err_und_q;

endmodule

// File: tb/tb_layer0_line_buffer.sv
// Randomized bench for layer0_line_buffer against a queue-based model
// of full rows, bank ownership and read-port contents.
module tb_layer0_line_buffer;

    import layer0_pkg::*;

    logic        sclk = 1'b0;
    logic        s_rst;
    logic        rd_en;
    logic [1:0]  rd_bank;
    logic [8:0]  rd_addr;
    logic [63:0] rd_data;
    logic        row_release;
    logic [2:0]  rows_full;
    logic [1:0]  head_bank;
    logic        row_done;
    logic [1:0]  done_bank;
    logic        err_misalign;
    logic        err_underflow;

    layer0_line_buffer_if #(.DATA_W(64)) fb ();

    layer0_line_buffer dut (
        .sclk          (sclk),
        .s_rst         (s_rst),
        .feat          (fb),
        .rd_en         (rd_en),
        .rd_bank       (rd_bank),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .row_release   (row_release),
        .rows_full     (rows_full),
        .head_bank     (head_bank),
        .row_done      (row_done),
        .done_bank     (done_bank),
        .err_misalign  (err_misalign),
        .err_underflow (err_underflow)
    );

    always #5 sclk = ~sclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: RAM image, FIFO of full banks, release pointer.
    logic [63:0] m_mem [NUM_ROWS][IMG_W];
    int          full_q [$];
    int          m_head;
    int          m_col;
    bit          m_writing;
    bit          m_errm;
    bit          m_erru;
    bit          m_done;
    int          m_done_bank;
    logic [63:0] m_rd;
    bit          m_rd_known;
    int          done_cnt;
    int          last_done_bank;

    function automatic bit m_ready();
        return m_writing || (full_q.size() < NUM_ROWS);
    endfunction

    function automatic bit is_full(input int b);
        foreach (full_q[i]) if (full_q[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        full_q.delete();
        m_head      = 0;
        m_col       = 0;
        m_writing   = 0;
        m_errm      = 0;
        m_erru      = 0;
        m_done      = 0;
        m_done_bank = 0;
        m_rd        = '0;
        m_rd_known  = 1;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".ready"}, fb.ready, m_ready());
        chk({ctx, ".rows_full"}, rows_full, full_q.size());
        chk({ctx, ".head_bank"}, head_bank, m_head);
        chk({ctx, ".row_done"}, row_done, m_done);
        chk({ctx, ".done_bank"}, done_bank, m_done_bank);
        chk({ctx, ".err_misalign"}, err_misalign, m_errm);
        chk({ctx, ".err_underflow"}, err_underflow, m_erru);
        if (m_rd_known) chk({ctx, ".rd_data"}, rd_data, m_rd);
    endtask

    task automatic step(input bit v, input logic [63:0] d, input bit l,
                        input bit rel, input bit re, input int rb,
                        input int ra);
        bit          acc;
        bit          rd_ok;
        int          pre;
        int          wb;
        logic [63:0] rd_exp;
        fb.feature_valid = v;
        fb.feature_data  = d;
        fb.feature_last  = l;
        row_release      = rel;
        rd_en            = re;
        rd_bank          = 2'(rb);
        rd_addr          = 9'(ra);
        acc    = v && m_ready();
        pre    = full_q.size();
        wb     = (m_head + pre) % NUM_ROWS;
        rd_ok  = re && is_full(rb) && (ra < IMG_W);
        rd_exp = rd_ok ? m_mem[rb][ra] : '0;
        @(posedge sclk);
        #1;
        m_done = 0;
        if (acc) begin
            m_mem[wb][m_col] = d;
            if (m_col == IMG_W - 1) begin
                m_done      = 1;
                m_done_bank = wb;
                m_col       = 0;
                m_writing   = 0;
            end else if (l) begin
                m_errm    = 1;
                m_col     = 0;
                m_writing = 0;
            end else begin
                m_col++;
                m_writing = 1;
            end
        end
        if (rel) begin
            if (pre > 0) begin
                void'(full_q.pop_front());
                m_head = (m_head + 1) % NUM_ROWS;
            end else begin
                m_erru = 1;
            end
        end
        if (m_done) full_q.push_back(wb);
        if (re) begin
            m_rd       = rd_exp;
            m_rd_known = rd_ok;
        end
        if (row_done === 1'b1) begin
            done_cnt++;
            last_done_bank = int'(done_bank);
        end
        check_outputs("step");
    endtask

    task automatic send_beat(input logic [63:0] d, input bit l,
                             input bit rel);
        bit acc;
        int budget;
        budget = 0;
        do begin
            acc = m_ready();
            step(1'b1, d, l, rel && acc, 1'($urandom % 2),
                 int'($urandom % NUM_ROWS), int'($urandom % IMG_W));
            budget++;
        end while (!acc && budget < 64);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_row(input bit rnd, input int nbeats,
                            input int last_at, input bit rel_last);
        logic [63:0] d;
        for (int c = 0; c < nbeats; c++) begin
            d = rnd ? {$urandom, $urandom} : 64'(c);
            send_beat(d, c == last_at, rel_last && (c == nbeats - 1));
        end
    endtask

    task automatic idle_read(input int rb, input int ra);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, rb, ra);
    endtask

    task automatic do_reset();
        s_rst            = 1'b1;
        fb.feature_valid = 1'b0;
        fb.feature_data  = '0;
        fb.feature_last  = 1'b0;
        row_release      = 1'b0;
        rd_en            = 1'b0;
        rd_bank          = '0;
        rd_addr          = '0;
        #2;
        model_reset();
        check_outputs("rst_async");
        @(posedge sclk);
        #1;
        s_rst = 1'b0;
        check_outputs("rst");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        done_cnt       = 0;
        last_done_bank = -1;
        do_reset();

        // Single row with data = column index.
        send_row(1'b0, IMG_W, IMG_W - 1, 1'b0);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_bank", last_done_bank, 0);
        chk("t1_rows_full", rows_full, 1);
        idle_read(0, 100);
        chk("t1_rd100", rd_data, 100);

        // Backpressure: four rows fill every bank, fifth stalls.
        do_reset();
        for (int r = 0; r < 4; r++) send_row(1'b1, IMG_W, IMG_W - 1, 1'b0);
        chk("t2_rows_full", rows_full, 4);
        chk("t2_ready_low", fb.ready, 0);
        for (int i = 0; i < 5; i++)
            step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("t2_stalled", rows_full, 4);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("t2_ready_high", fb.ready, 1);
        chk("t2_head", head_bank, 1);
        send_row(1'b0, IMG_W, IMG_W - 1, 1'b0);
        chk("t2_row5_bank", last_done_bank, 0);
        idle_read(0, 7);
        chk("t2_row5_rd", rd_data, 7);

        // Completion and release on the same edge.
        do_reset();
        send_row(1'b1, IMG_W, IMG_W - 1, 1'b0);
        send_row(1'b1, IMG_W, IMG_W - 1, 1'b1);
        chk("t3_rows_full", rows_full, 1);
        chk("t3_head", head_bank, 1);

        // Misaligned last on beat 200.
        do_reset();
        done_cnt = 0;
        send_row(1'b1, 201, 200, 1'b0);
        chk("t4_err", err_misalign, 1);
        chk("t4_no_done", done_cnt, 0);
        send_row(1'b1, IMG_W, IMG_W - 1, 1'b0);
        chk("t4_bank", last_done_bank, 0);
        chk("t4_rows_full", rows_full, 1);

        // Release with nothing full.
        do_reset();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("t5_underflow", err_underflow, 1);
        chk("t5_rows_full", rows_full, 0);

        // Reset in the middle of row 2.
        do_reset();
        send_row(1'b1, IMG_W, IMG_W - 1, 1'b0);
        send_row(1'b1, 300, -1, 1'b0);
        do_reset();
        chk("t6_rows_full", rows_full, 0);
        last_done_bank = -1;
        send_row(1'b1, IMG_W, IMG_W - 1, 1'b0);
        chk("t6_bank", last_done_bank, 0);
        chk("t6_rows_full", rows_full, 1);

        // Random traffic, releases and reads.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit lst;
            lst = (m_col == IMG_W - 1) ? 1'($urandom % 2)
                                       : ($urandom % 300 == 0);
            step(($urandom % 10) < 8, {$urandom, $urandom}, lst,
                 ($urandom % 8) == 0, 1'($urandom % 2),
                 int'($urandom % NUM_ROWS), int'($urandom % IMG_W));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
